ff_fifo_stream_reader: RTL and testbench

// - Read-side consumer for the ff_fifo_pow2_depth push/pop FIFO: issues pop, converts head word to a valid/ready stream.
// - Holds a 2-entry output skid buffer so fifo_pop never depends combinationally on down_ready.
// - Sits between the FIFO read port (empty, read_data, pop) and any valid/ready sink.
//

---
 rtl/ff_fifo_stream_reader.sv | 89 ++++++++
 tb/tb_ff_fifo_stream_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_fifo_stream_reader.sv
// Read-side consumer for a push/pop FIFO: pops head words into a 2-entry skid buffer
// and presents them as a valid/ready stream. Optional macro FF_FIFO_STREAM_READER_COUNT_EN adds word_count.
module ff_fifo_stream_reader #(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_read_data,
    output logic             fifo_pop,
    input  logic             flush,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [width-1:0] down_data
`ifdef FF_FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [31:0]      word_count
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [width-1:0] entry0;
    logic [width-1:0] entry1;
    logic             xfer;

    // Pop depends only on registered occupancy, never on down_ready.
    assign fifo_pop   = !fifo_empty && (state != S_TWO) && !flush && !rst;
    assign down_valid = (state != S_EMPTY);
    assign down_data  = entry0;
    assign xfer       = down_valid && down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            entry0 <= '0;
            entry1 <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (fifo_pop) begin
                        state  <= S_ONE;
                        entry0 <= fifo_read_data;
                    end
                end
                S_ONE: begin
                    if (fifo_pop && xfer) begin
                        entry0 <= fifo_read_data;
                    end else if (fifo_pop) begin
                        state  <= S_TWO;
                        entry1 <= fifo_read_data;
                    end else if (xfer) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (xfer) begin
                        state  <= S_ONE;
                        entry0 <= entry1;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

`ifdef FF_FIFO_STREAM_READER_COUNT_EN
    // Counts every accepted word, including one accepted in a flush cycle.
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign word_count = count_q;
`endif

endmodule

// File: tb/tb_ff_fifo_stream_reader.sv
// Bench for ff_fifo_stream_reader: emulated FIFO, queue-based occupancy model checked
// every cycle, plus directed literal checks for reset, streaming, backpressure, flush, counter.
module tb_ff_fifo_stream_reader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic [W-1:0] fifo_read_data;
    logic         fifo_pop;
    logic         flush;
    logic         down_valid;
    logic         down_ready;
    logic [W-1:0] down_data;
`ifdef FF_FIFO_STREAM_READER_COUNT_EN
    logic [31:0]  word_count;
`endif

    ff_fifo_stream_reader #(.width(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_pop       (fifo_pop),
        .flush          (flush),
        .down_valid     (down_valid),
        .down_ready     (down_ready),
        .down_data      (down_data)
`ifdef FF_FIFO_STREAM_READER_COUNT_EN
        ,
        .word_count     (word_count)
`endif
    );

    always #5 clk = ~clk;

    // Emulated FIFO: array with read/write indices, head visible combinationally.
    logic [W-1:0] mem [0:4095];
    int           rdp = 0;
    int           wrp = 0;
    assign fifo_empty     = (rdp == wrp);
    assign fifo_read_data = mem[rdp & 4095];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] w);
        mem[wrp & 4095] = w;
        wrp++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: buffer contents as a queue; pop whenever there is data and room.
    logic [W-1:0] mbuf[$];
    logic [31:0]  mcount = 0;
    bit           started = 0;
    logic [W-1:0] dut_log[$];

    always @(posedge clk) begin
        bit mpop;
        bit mxfer;
        mpop  = (rdp != wrp) && (mbuf.size() < 2) && !flush && !rst;
        mxfer = (mbuf.size() != 0) && down_ready;
        if (rst) begin
            mbuf.delete();
            rdp <= wrp;
            mcount = 0;
            started = 1;
        end else begin
            if (mxfer) begin
                void'(mbuf.pop_front());
                mcount = mcount + 32'd1;
            end
            if (flush) begin
                mbuf.delete();
            end else if (mpop) begin
                mbuf.push_back(mem[rdp & 4095]);
                rdp <= rdp + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid", {31'd0, down_valid}, {31'd0, mbuf.size() != 0});
            if (mbuf.size() != 0) check("data", {24'd0, down_data}, {24'd0, mbuf[0]});
            check("pop", {31'd0, fifo_pop},
                  {31'd0, (rdp != wrp) && (mbuf.size() < 2) && !flush && !rst});
            check("occupancy_le2", {31'd0, mbuf.size() <= 2}, 32'd1);
`ifdef FF_FIFO_STREAM_READER_COUNT_EN
            check("word_count", word_count, mcount);
`endif
            if (down_valid && down_ready) dut_log.push_back(down_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] rin[$];

    initial begin
        int npop;
        int errs;
        int cyc;
        rst = 1'b1;
        flush = 1'b0;
        down_ready = 1'b0;

        // Reset held 2 cycles with data sitting in the FIFO.
        tick();
        push(8'hAA);
        push(8'hBB);
        @(negedge clk);
        check("rst_pop", {31'd0, fifo_pop}, 32'd0);
        check("rst_valid", {31'd0, down_valid}, 32'd0);
        check("rst_data", {24'd0, down_data}, 32'd0);
        tick();
        rst = 1'b0;

        // Streaming 01..08 with ready high.
        down_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        @(negedge clk);
        check("stream_latency_valid", {31'd0, down_valid}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("stream_valid", {31'd0, down_valid}, 32'd1);
            check("stream_data", {24'd0, down_data}, i);
        end
        @(negedge clk);
        check("stream_done", {31'd0, down_valid}, 32'd0);

        // Backpressure: exactly two pops, then head holds.
        tick();
        down_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        npop = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fifo_pop) npop++;
        end
        check("bp_pops", npop, 2);
        check("bp_hold", {24'd0, down_data}, 32'h11);
        dut_log.delete();
        tick();
        down_ready = 1'b1;
        repeat (8) tick();
        check("bp_count", dut_log.size(), 4);
        if (dut_log.size() == 4) begin
            check("bp_w0", {24'd0, dut_log[0]}, 32'h11);
            check("bp_w1", {24'd0, dut_log[1]}, 32'h22);
            check("bp_w2", {24'd0, dut_log[2]}, 32'h33);
            check("bp_w3", {24'd0, dut_log[3]}, 32'h44);
        end

        // Random ready over 256 words.
        dut_log.delete();
        rin.delete();
        for (int i = 0; i < 256; i++) begin
            rin.push_back(W'($urandom_range(0, 255)));
            push(rin[i]);
        end
        cyc = 0;
        while (dut_log.size() < 256 && cyc < 3000) begin
            down_ready = ($urandom_range(0, 1) == 1);
            tick();
            cyc++;
        end
        check("rand_count", dut_log.size(), 256);
        errs = 0;
        for (int i = 0; i < 256 && i < dut_log.size(); i++)
            if (dut_log[i] !== rin[i]) errs++;
        check("rand_order_errs", errs, 0);

        // Flush from S_TWO holding A,B with C still in the FIFO.
        down_ready = 1'b0;
        repeat (3) tick();
        push(8'hA0); push(8'hB0); push(8'hC0);
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_pop", {31'd0, fifo_pop}, 32'd0);
        check("flush_head", {24'd0, down_data}, 32'hA0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, down_valid}, 32'd0);
        check("flush_pop_c", {31'd0, fifo_pop}, 32'd1);
        tick();
        @(negedge clk);
        check("flush_c_valid", {31'd0, down_valid}, 32'd1);
        check("flush_c_data", {24'd0, down_data}, 32'hC0);
        tick();
        down_ready = 1'b1;
        repeat (3) tick();

`ifdef FF_FIFO_STREAM_READER_COUNT_EN
        // Counter: 10 transfers, flush, 3 transfers; then wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) push(W'(8'h50 + i));
        repeat (12) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) push(W'(8'h70 + i));
        repeat (5) tick();
        @(negedge clk);
        check("count_13", word_count, 32'd13);
        tick();
        force dut.count_q = 32'hFFFF_FFFF;
        mcount = 32'hFFFF_FFFF;
        tick();
        release dut.count_q;
        @(negedge clk);
        check("count_max", word_count, 32'hFFFF_FFFF);
        tick();
        push(8'h99);
        repeat (4) tick();
        @(negedge clk);
        check("count_wrap", word_count, 32'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
